// File: rtl/mem_pkg.sv
// Shared types and constants for the unified-memory responder: FSM states,
// fun3 access-size encodings and the wait-counter width.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int CNT_W = 4;

  // Unlisted fun3 encodings fall back to word accesses.
  function automatic size_t f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_array.sv
// Word-organised single-port storage: byte-enable synchronous write,
// asynchronous read of the same word. Contents are never reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory responder: one access per Req, WAIT_CYCLES wait states, one-cycle Ready with registered RD.
// Define MEM_MISALIGN_TRAP_EN to flag misaligned accesses instead of silently aligning them.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Req,
  input  logic        MemWrite,
  input  logic [31:0] Adr,
  input  logic [31:0] WD,
  input  logic [2:0]  fun3,
  output logic        Ready,
  output logic [31:0] RD,
  output logic        Misaligned
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [AW+1:0]    adr_q;
  logic [31:0]      wd_q;
  logic             we_q;
  logic [2:0]       f3_q;
  logic [31:0]      rd_q;

  logic             idle;
  logic [AW+1:0]    acc_adr;
  logic [AW+1:0]    eff_adr;
  logic [31:0]      acc_wd;
  logic             acc_we;
  logic [2:0]       acc_f3;
  size_t            acc_sz;
  logic             acc_mis;

  logic [31:0]      rdata;
  logic [31:0]      wdata;
  logic [3:0]       be;
  logic             wr_en;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      load_val;

  logic             unused_adr;
  assign unused_adr = ^Adr[31:AW+2];

  // In IDLE the access comes straight from the inputs so a zero-wait load
  // resolves on the capture edge; afterwards only captured values are used.
  assign idle    = (state_q == IDLE);
  assign acc_adr = idle ? Adr[AW+1:0] : adr_q;
  assign acc_wd  = idle ? WD          : wd_q;
  assign acc_we  = idle ? MemWrite    : we_q;
  assign acc_f3  = idle ? fun3        : f3_q;
  assign acc_sz  = f3_size(acc_f3);

  always_comb begin
    acc_mis = 1'b0;
    case (acc_sz)
      SZ_H:    acc_mis = acc_adr[0];
      SZ_W:    acc_mis = |acc_adr[1:0];
      default: acc_mis = 1'b0;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign eff_adr = acc_adr;
  assign wr_en   = (state_q == RESP) && we_q && !acc_mis;
`else
  always_comb begin
    eff_adr = acc_adr;
    case (acc_sz)
      SZ_H:    eff_adr[0]   = 1'b0;
      SZ_W:    eff_adr[1:0] = 2'b00;
      default: eff_adr      = acc_adr;
    endcase
  end
  assign wr_en = (state_q == RESP) && we_q;
`endif

  mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_mem_array (
    .clk  (Clk),
    .we   (wr_en),
    .be   (be),
    .addr (eff_adr[AW+1:2]),
    .wdata(wdata),
    .rdata(rdata)
  );

  always_comb begin
    case (eff_adr[1:0])
      2'd0:    ld_byte = rdata[7:0];
      2'd1:    ld_byte = rdata[15:8];
      2'd2:    ld_byte = rdata[23:16];
      default: ld_byte = rdata[31:24];
    endcase
    ld_half = eff_adr[1] ? rdata[31:16] : rdata[15:0];
    case (acc_f3)
      F3_B:    load_val = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   load_val = {24'b0, ld_byte};
      F3_H:    load_val = {{16{ld_half[15]}}, ld_half};
      F3_HU:   load_val = {16'b0, ld_half};
      default: load_val = rdata;
    endcase
`ifdef MEM_MISALIGN_TRAP_EN
    if (acc_mis) load_val = '0;
`endif
  end

  // Sub-word stores replicate the data across lanes and let the byte enables pick.
  always_comb begin
    be    = 4'b1111;
    wdata = acc_wd;
    case (acc_sz)
      SZ_B: begin
        be    = 4'b0001 << eff_adr[1:0];
        wdata = {4{acc_wd[7:0]}};
      end
      SZ_H: begin
        be    = eff_adr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{acc_wd[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = acc_wd;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Req) state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Ready = 1'b0;
    if (state_q == RESP) Ready = 1'b1;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q <= '0;
      adr_q <= '0;
      wd_q  <= '0;
      we_q  <= 1'b0;
      f3_q  <= '0;
      rd_q  <= '0;
    end else begin
      if (idle && Req) begin
        adr_q <= Adr[AW+1:0];
        wd_q  <= WD;
        we_q  <= MemWrite;
        f3_q  <= fun3;
        cnt_q <= CNT_LOAD;
      end else if (state_q == WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (state_d == RESP && !acc_we) rd_q <= load_val;
    end
  end

  assign RD = rd_q;

`ifdef MEM_MISALIGN_TRAP_EN
  logic mis_q;
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                mis_q <= 1'b0;
    else if (state_d == RESP)  mis_q <= acc_mis;
    else                       mis_q <= 1'b0;
  end
  assign Misaligned = mis_q;
`else
  assign Misaligned = 1'b0;
`endif

endmodule
